// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the irrigation valve sequencer.
// A state encoding of zero is IDLE so that a cleared register is a safe valve-off state.
package irrigation_pkg;

   localparam int DEF_TICK_DIV = 50_000_000;
   localparam int DEF_RUN_SEC  = 10;
   localparam int DEF_COOL_SEC = 5;
   localparam int REM_W        = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SPRINKLE = 3'd1,
      ST_DRIP     = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   typedef logic [REM_W-1:0] rem_t;

endpackage

// File: rtl/irrigation_scheduler_tick_prescaler.sv
// Free-running divider giving a one-cycle tick every TICK_DIV cycles.
// clr restarts the count so a tick lands exactly TICK_DIV cycles after it.
module tick_prescaler
   import irrigation_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/irrigation_scheduler.sv
// Timed valve sequencer: bounded sprinkler/drip run, mandatory cooldown, fault lockout.
// All outputs are registered and change on the edge that moves the FSM.
module irrigation_scheduler
   import irrigation_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int RUN_SEC  = DEF_RUN_SEC,
   parameter int COOL_SEC = DEF_COOL_SEC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sprinkler_req,
   input  logic             drip_req,
   input  logic             erro,
   input  logic             alarme,
   output logic             sprinkler_on,
   output logic             drip_on,
   output logic             busy,
   output logic             fault,
   output logic             done,
   output logic [REM_W-1:0] remaining
);

   state_t state;
   state_t state_nxt;

   logic tick;
   logic flt;
   logic run_st;
   logic active_req;
   logic last_tick;
   logic phase_change;

   logic sprinkler_d;
   logic drip_d;
   logic busy_d;
   logic fault_d;
   logic done_d;
   rem_t rem_d;

   assign flt          = erro | alarme;
   assign run_st       = (state == ST_SPRINKLE) || (state == ST_DRIP);
   assign active_req   = (state == ST_SPRINKLE) ? sprinkler_req : drip_req;
   assign last_tick    = tick && (remaining == rem_t'(1));
   assign phase_change = (state_nxt != state);

   // Every state entry restarts the second count so each phase lasts whole ticks.
   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (phase_change),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (flt) begin
               state_nxt = ST_FAULT;
            end else if (sprinkler_req) begin
               state_nxt = ST_SPRINKLE;
            end else if (drip_req) begin
               state_nxt = ST_DRIP;
            end
         end
         ST_SPRINKLE, ST_DRIP: begin
            if (flt) begin
               state_nxt = ST_FAULT;
            end else if (!active_req || last_tick) begin
               state_nxt = ST_COOLDOWN;
            end
         end
         ST_COOLDOWN: begin
            if (flt) begin
               state_nxt = ST_FAULT;
            end else if (last_tick) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (!flt) begin
               state_nxt = ST_COOLDOWN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      sprinkler_d = (state_nxt == ST_SPRINKLE);
      drip_d      = (state_nxt == ST_DRIP);
      busy_d      = (state_nxt != ST_IDLE);
      fault_d     = (state_nxt == ST_FAULT);
      done_d      = run_st && !flt && active_req && last_tick;
      rem_d       = remaining;
      if (phase_change) begin
         case (state_nxt)
            ST_SPRINKLE, ST_DRIP: rem_d = rem_t'(RUN_SEC);
            ST_COOLDOWN:          rem_d = rem_t'(COOL_SEC);
            default:              rem_d = '0;
         endcase
      end else if ((run_st || (state == ST_COOLDOWN)) && tick) begin
         rem_d = remaining - rem_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sprinkler_on <= 1'b0;
         drip_on      <= 1'b0;
         busy         <= 1'b0;
         fault        <= 1'b0;
         done         <= 1'b0;
         remaining    <= '0;
      end else begin
         sprinkler_on <= sprinkler_d;
         drip_on      <= drip_d;
         busy         <= busy_d;
         fault        <= fault_d;
         done         <= done_d;
         remaining    <= rem_d;
      end
   end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed and randomized bench for irrigation_scheduler against a cycle-count reference model.
module tb_irrigation_scheduler;

   localparam int TD = 4;
   localparam int RS = 3;
   localparam int CS = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       sprinkler_req;
   logic       drip_req;
   logic       erro;
   logic       alarme;
   logic       sprinkler_on;
   logic       drip_on;
   logic       busy;
   logic       fault;
   logic       done;
   logic [7:0] remaining;

   always #5 clk = ~clk;

   irrigation_scheduler #(
      .TICK_DIV (TD),
      .RUN_SEC  (RS),
      .COOL_SEC (CS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sprinkler_req (sprinkler_req),
      .drip_req      (drip_req),
      .erro          (erro),
      .alarme        (alarme),
      .sprinkler_on  (sprinkler_on),
      .drip_on       (drip_on),
      .busy          (busy),
      .fault         (fault),
      .done          (done),
      .remaining     (remaining)
   );

   // Reference model: phase plus cycles elapsed in that phase.
   typedef enum int {M_IDLE, M_SPR, M_DRIP, M_COOL, M_FAULT} mphase_t;
   mphase_t m_phase = M_IDLE;
   int      m_elapsed = 0;
   bit      m_done = 0;

   int checks = 0;
   int errors = 0;
   int n_spr, n_busy, n_done, n_fault;

   task automatic enter(input mphase_t p);
      m_phase   = p;
      m_elapsed = 0;
   endtask

   task automatic model_edge();
      bit flt;
      bit act;
      flt    = erro || alarme;
      m_done = 0;
      if (rst) begin
         enter(M_IDLE);
      end else begin
         case (m_phase)
            M_IDLE: begin
               if (flt) enter(M_FAULT);
               else if (sprinkler_req) enter(M_SPR);
               else if (drip_req) enter(M_DRIP);
            end
            M_SPR, M_DRIP: begin
               act = (m_phase == M_SPR) ? sprinkler_req : drip_req;
               if (flt) enter(M_FAULT);
               else if (!act) enter(M_COOL);
               else if (m_elapsed == RS * TD - 1) begin
                  enter(M_COOL);
                  m_done = 1;
               end else m_elapsed++;
            end
            M_COOL: begin
               if (flt) enter(M_FAULT);
               else if (m_elapsed == CS * TD - 1) enter(M_IDLE);
               else m_elapsed++;
            end
            default: begin
               if (!flt) enter(M_COOL);
            end
         endcase
      end
   endtask

   function automatic int exp_rem();
      case (m_phase)
         M_SPR, M_DRIP: return RS - m_elapsed / TD;
         M_COOL:        return CS - m_elapsed / TD;
         default:       return 0;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      logic [12:0] obs;
      logic [12:0] exp;
      obs = {sprinkler_on, drip_on, busy, fault, done, remaining};
      exp = {m_phase == M_SPR, m_phase == M_DRIP, m_phase != M_IDLE,
             m_phase == M_FAULT, m_done, 8'(exp_rem())};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed spr/drip/busy/fault/done/rem=%b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
      n_spr   += int'(sprinkler_on);
      n_busy  += int'(busy);
      n_done  += int'(done);
      n_fault += int'(fault);
   endtask

   task automatic clr_counts();
      n_spr = 0; n_busy = 0; n_done = 0; n_fault = 0;
   endtask

   task automatic drive(input bit s, input bit d, input bit e, input bit a);
      sprinkler_req = s; drip_req = d; erro = e; alarme = a;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0);
      clr_counts();
      repeat (3) step("reset");
      rst = 1'b0;
      repeat (20) step("idle");

      // Full sprinkler run, held request restarts right after IDLE.
      drive(1, 0, 0, 0);
      clr_counts();
      repeat (21) step("full_run");
      check_val("full_run_valve_cycles", n_spr, RS * TD);
      check_val("full_run_busy_cycles", n_busy, (RS + CS) * TD);
      check_val("full_run_done_pulses", n_done, 1);
      step("restart");
      check_val("restart_valve", int'(sprinkler_on), 1);
      drive(0, 0, 0, 0);
      repeat (10) step("drain1");

      // Simultaneous requests: sprinkler wins.
      drive(1, 1, 0, 0);
      step("simul");
      check_val("simul_spr_drip", int'({sprinkler_on, drip_on}), 2);
      drive(0, 0, 0, 0);
      repeat (10) step("drain2");

      // Early abort of a drip run at run cycle 5.
      drive(0, 1, 0, 0);
      repeat (5) step("drip_run");
      drive(0, 0, 0, 0);
      clr_counts();
      step("abort");
      check_val("abort_drip_off", int'(drip_on), 0);
      check_val("abort_rem", int'(remaining), CS);
      repeat (8) step("abort_cool");
      check_val("abort_busy_cycles", n_busy, CS * TD);
      check_val("abort_no_done", n_done, 0);

      // Error mid-run for 7 cycles, then full cooldown.
      drive(1, 0, 0, 0);
      repeat (6) step("run_pre_fault");
      drive(1, 0, 1, 0);
      clr_counts();
      repeat (7) step("fault");
      check_val("fault_cycles", n_fault, 7);
      check_val("fault_valve_off", n_spr, 0);
      drive(0, 0, 0, 0);
      clr_counts();
      repeat (9) step("fault_cool");
      check_val("fault_cool_cycles", n_busy, CS * TD);
      check_val("fault_no_done", n_done, 0);

      // Alarm pulsed during cooldown re-enters FAULT and restarts the cooldown.
      drive(0, 0, 1, 0);
      step("pre_alarm_fault");
      drive(0, 0, 0, 0);
      repeat (3) step("cool_pre_alarm");
      drive(1, 0, 0, 1);
      step("alarm");
      check_val("alarm_fault", int'(fault), 1);
      drive(1, 0, 0, 0);
      clr_counts();
      repeat (8) step("alarm_cool");
      check_val("alarm_cool_no_valve", n_spr, 0);
      drive(0, 0, 0, 0);
      repeat (3) step("drain3");

      // Reset mid-run at run cycle 7.
      drive(1, 0, 0, 0);
      repeat (7) step("run_pre_rst");
      rst = 1'b1;
      step("rst_mid_run");
      check_val("rst_rem", int'(remaining), 0);
      check_val("rst_outputs", int'({sprinkler_on, drip_on, busy, fault, done}), 0);
      rst = 1'b0;
      drive(0, 0, 0, 0);
      repeat (3) step("post_rst");

      // Randomized traffic with sticky requests and rare faults/resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(11) == 0) sprinkler_req = ~sprinkler_req;
         if ($urandom_range(11) == 0) drip_req = ~drip_req;
         if (erro) erro = ($urandom_range(3) != 0);
         else erro = ($urandom_range(79) == 0);
         if (alarme) alarme = ($urandom_range(3) != 0);
         else alarme = ($urandom_range(79) == 0);
         rst = ($urandom_range(399) == 0);
         step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
